// File: rtl/inst_buffer.sv
// inst_buffer: circular 2-in/2-out instruction queue between fetch and dispatch.
// Flush has priority; a single free slot is never used so 2-wide fetch stays atomic.
module inst_buffer #(
  parameter int DEPTH  = 8,
  parameter int INST_W = 32,
  parameter int PC_W   = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [1:0]             if_nFetched,
  input  logic [INST_W-1:0]      if_inst0,
  input  logic [INST_W-1:0]      if_inst1,
  input  logic [PC_W-1:0]        if_pc0,
  input  logic [PC_W-1:0]        if_pc1,
  input  logic [1:0]             haz_nDispatched,
  input  logic                   br_pred_wrong,
  output logic                   ib_stall,
  output logic [1:0]             ib_nIsnBuffer,
  output logic [INST_W-1:0]      ib_inst0,
  output logic [INST_W-1:0]      ib_inst1,
  output logic [PC_W-1:0]        ib_pc0,
  output logic [PC_W-1:0]        ib_pc1,
  output logic [$clog2(DEPTH):0] ib_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [CW-1:0] count_q, count_d;
  logic [1:0] nf, enq, deq;
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem [DEPTH];
  assign head1 = head_q + AW'(1);
  assign tail1 = tail_q + AW'(1);
  assign ib_count = count_q;
  assign ib_stall = count_q > CW'(DEPTH - 2);
  assign ib_nIsnBuffer = count_q >= CW'(2) ? 2'd2 : count_q[1:0];
  assign ib_inst0 = count_q != '0 ? inst_mem[head_q] : '0;
  assign ib_pc0 = count_q != '0 ? pc_mem[head_q] : '0;
  assign ib_inst1 = count_q >= CW'(2) ? inst_mem[head1] : '0;
  assign ib_pc1 = count_q >= CW'(2) ? pc_mem[head1] : '0;
  assign nf = if_nFetched == 2'd3 ? 2'd2 : if_nFetched;
  assign enq = (ib_stall || br_pred_wrong) ? 2'd0 : nf;
  // over-grants are clamped to what is actually visible
  assign deq = haz_nDispatched > ib_nIsnBuffer ? ib_nIsnBuffer : haz_nDispatched;
  always_comb begin
    head_d = br_pred_wrong ? '0 : head_q + AW'(deq);
    tail_d = br_pred_wrong ? '0 : tail_q + AW'(enq);
    count_d = br_pred_wrong ? '0 : count_q + CW'(enq) - CW'(deq);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (enq != 2'd0) begin
      inst_mem[tail_q] <= if_inst0;
      pc_mem[tail_q] <= if_pc0;
    end
    if (enq == 2'd2) begin
      inst_mem[tail1] <= if_inst1;
      pc_mem[tail1] <= if_pc1;
    end
  end
endmodule
